ed_square_unit: RTL and testbench

Sequential Euclidean-distance engine for the GAM associative memory. It computes the integer Euclidean distance between an input pattern and one stored node weight vector, plus the square of that distance. One instance serves each class/node slot in the recall path, where the squared distance is compared against the recall threshold Tk.

---
 rtl/ed_square_unit.sv | 151 +++++++++++++++
 tb/tb_ed_square_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ed_square_unit.sv
// Purpose: integer Euclidean distance (floor sqrt of sum of squared diffs) and its square for one GAM node.
// Latency: result pulse on out_valid ROOT_W+2 edges after accept (sum edge, ROOT_W root edges, output edge).
// Backpressure: in_ready low while busy; in_valid ignored then; a new pair may be accepted in the DONE cycle.
module ed_square_unit #(
    parameter int DIM    = 8,
    parameter int ELEM_W = 8,
    parameter int SUM_W  = 2*ELEM_W + $clog2(DIM),
    parameter int ROOT_W = (SUM_W+1)/2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIM*ELEM_W-1:0]   x,
    input  logic [DIM*ELEM_W-1:0]   w,
    output logic                    out_valid,
    output logic [31:0]             ed,
    output logic [63:0]             ed_square
);

    localparam int RAD_W = 2*ROOT_W;
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROOT,
        S_FIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RAD_W-1:0]    rad_q, rad_d;      // radicand, consumed two bits per step from the top
    logic [ROOT_W-1:0]   rem_q, rem_d;      // partial remainder
    logic [ROOT_W-1:0]   root_q, root_d;    // partial root, grows one bit per step
    logic [ROOT_W-1:0]   ed_q, ed_d;
    logic [RAD_W-1:0]    ed_sq_q, ed_sq_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                armed_q, armed_d;  // blocks an accept on the first edge after reset release

    logic [SUM_W-1:0]    sum_d;
    logic [ROOT_W+1:0]   rem_shift;
    logic [ROOT_W+1:0]   trial;
    logic                take;
    logic                accept;

    // Square of |a-b|; the absolute difference stays at element width.
    function automatic logic [SUM_W-1:0] sq_diff(input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b);
        logic [ELEM_W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return SUM_W'(d) * SUM_W'(d);
    endfunction

    assign accept = in_valid && in_ready_q && armed_q;

    // Sum of squared element differences, captured on the accept edge.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < DIM; i++) begin
            sum_d = sum_d + sq_diff(x[i*ELEM_W +: ELEM_W], w[i*ELEM_W +: ELEM_W]);
        end
    end

    // One restoring square-root step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        rem_shift = {rem_q, rad_q[RAD_W-1 -: 2]};
        trial     = {root_q, 2'b01};
        take      = (rem_shift >= trial);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        ed_d        = ed_q;
        ed_sq_d     = ed_sq_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        armed_d     = 1'b1;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d    = S_ROOT;
                    rad_d      = RAD_W'(sum_d);
                    rem_d      = '0;
                    root_d     = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ROOT: begin
                rad_d  = {rad_q[RAD_W-3:0], 2'b00};
                rem_d  = take ? ROOT_W'(rem_shift - trial) : rem_shift[ROOT_W-1:0];
                root_d = {root_q[ROOT_W-2:0], take};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ROOT_W-1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                ed_d        = root_q;
                ed_sq_d     = RAD_W'(root_q) * RAD_W'(root_q);
                out_valid_d = 1'b1;
                in_ready_d  = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            ed_q        <= '0;
            ed_sq_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            ed_q        <= ed_d;
            ed_sq_q     <= ed_sq_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            armed_q     <= armed_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ed        = 32'(ed_q);
    assign ed_square = 64'(ed_sq_q);

endmodule

// File: tb/tb_ed_square_unit.sv
// Bench for ed_square_unit: directed corner cases plus random pairs against an arithmetic reference.
// Reference computes the distance with plain integer maths and a search for the floor root.
// Outputs are sampled on falling edges; inputs change on falling edges.
module tb_ed_square_unit;

    localparam int DIM    = 8;
    localparam int ELEM_W = 8;
    localparam int VW     = DIM*ELEM_W;
    localparam int LAT    = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] x;
    logic [VW-1:0] w;
    logic          out_valid;
    logic [31:0]   ed;
    logic [63:0]   ed_square;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ed_square_unit #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .out_valid (out_valid),
        .ed        (ed),
        .ed_square (ed_square)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_sum(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint s = 0;
        for (int i = 0; i < DIM; i++) begin
            longint p = longint'(a[i*ELEM_W +: ELEM_W]);
            longint q = longint'(b[i*ELEM_W +: ELEM_W]);
            s += (p - q) * (p - q);
        end
        return s;
    endfunction

    function automatic longint ref_root(input longint s);
        longint r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec(input int maxv);
        logic [VW-1:0] v;
        for (int i = 0; i < DIM; i++) v[i*ELEM_W +: ELEM_W] = ELEM_W'($urandom_range(0, maxv));
        return v;
    endfunction

    // Present a pair for one cycle; returns at the falling edge after the accept edge.
    task automatic send(input logic [VW-1:0] xv, input logic [VW-1:0] wv);
        @(negedge clk);
        x = xv; w = wv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x = rand_vec(255);
        w = rand_vec(255);
    endtask

    // Wait for the result; n0 is the number of falling edges already seen since accept.
    task automatic wait_result(input string tag, input logic [VW-1:0] xv, input logic [VW-1:0] wv, input int n0);
        longint s = ref_sum(xv, wv);
        longint r = ref_root(s);
        int     n = n0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, longint'(n), longint'(LAT));
        check({tag, "_ed"}, longint'(ed), r);
        check({tag, "_sq"}, longint'(ed_square), r * r);
    endtask

    task automatic pulse_gap(input string tag);
        @(negedge clk);
        check({tag, "_pulse"}, longint'(out_valid), 0);
    endtask

    task automatic run_pair(input string tag, input logic [VW-1:0] xv, input logic [VW-1:0] wv);
        send(xv, wv);
        wait_result(tag, xv, wv, 1);
        pulse_gap(tag);
    endtask

    task automatic count_pulses(input string tag, input int cycles);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid === 1'b1) cnt++;
        end
        check(tag, longint'(cnt), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] xa, wa, xb, wb;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = VW'(64'h0403);
        w        = '0;
        repeat (3) @(negedge clk);
        check("rst_rdy", longint'(in_ready), 1);
        check("rst_vld", longint'(out_valid), 0);
        check("rst_ed", longint'(ed), 0);
        check("rst_sq", longint'(ed_square), 0);

        // in_valid held through reset release must not be taken on the release edge
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_noacc", longint'(in_ready), 1);
        in_valid = 1'b0;
        count_pulses("idle_nov", 20);
        check("idle_rdy", longint'(in_ready), 1);

        run_pair("pyth", VW'(64'h0403), '0);
        check("pyth_ed_k", longint'(ed), 5);
        check("pyth_sq_k", longint'(ed_square), 25);
        run_pair("pyth_swap", '0, VW'(64'h0403));
        run_pair("floor", VW'(64'h0501), '0);
        check("floor_ed_k", longint'(ed), 5);
        check("floor_sq_k", longint'(ed_square), 25);

        xa = rand_vec(255);
        run_pair("equal", xa, xa);

        run_pair("max", {DIM{8'hff}}, '0);
        check("max_ed_k", longint'(ed), 721);
        check("max_sq_k", longint'(ed_square), 519841);
        repeat (5) @(negedge clk);
        check("hold_ed", longint'(ed), 721);

        for (int k = 0; k < 16; k++) begin
            xa = rand_vec((k % 2 == 0) ? 255 : 15);
            wa = rand_vec((k % 2 == 0) ? 255 : 15);
            run_pair("rand", xa, wa);
        end

        // second in_valid while busy is ignored
        xa = rand_vec(255);
        wa = rand_vec(255);
        send(xa, wa);
        repeat (3) @(negedge clk);
        x = rand_vec(255);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("busy", xa, wa, 5);
        count_pulses("busy_single", 20);

        // back-to-back: accept the next pair in the DONE cycle
        xa = rand_vec(255);
        wa = rand_vec(255);
        xb = {DIM{8'h10}};
        wb = '0;
        send(xa, wa);
        wait_result("b2b_a", xa, wa, 1);
        x = xb; w = wb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("b2b_b", xb, wb, 1);
        pulse_gap("b2b_b");

        // reset five cycles into a computation
        send(rand_vec(255), rand_vec(255));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ed", longint'(ed), 0);
        check("mid_rst_sq", longint'(ed_square), 0);
        check("mid_rst_vld", longint'(out_valid), 0);
        check("mid_rst_rdy", longint'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_pulses("mid_rst_nov", 20);
        run_pair("post_rst", VW'(64'h0c_05), VW'(64'h00_00));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
